sum_block_accumulator: RTL and testbench



---
 rtl/sum_block_accumulator.sv | 106 ++++++++++
 tb/tb_sum_block_accumulator.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/sum_block_accumulator.sv
// Accumulates BLOCK_LEN unsigned adder samples into one block result (total, count,
// max, overflow) and hands it downstream over a valid/ready handshake.
module sum_block_accumulator #(
    parameter int IN_W      = 5,
    parameter int ACC_W     = 8,
    parameter int BLOCK_LEN = 4,
    parameter int CNT_W     = $clog2(BLOCK_LEN + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [IN_W-1:0]  in_sum,
    output logic             in_ready,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [ACC_W-1:0] out_total,
    output logic [CNT_W-1:0] out_count,
    output logic [IN_W-1:0]  out_max,
    output logic             out_overflow
);

    typedef enum logic {ACCUM, HOLD} state_t;

    state_t             r_state, w_state_next;
    logic [ACC_W-1:0]   r_acc, w_acc_next;
    logic [CNT_W-1:0]   r_cnt, w_cnt_next;
    logic [IN_W-1:0]    r_max, w_max_next;
    logic               r_ovf, w_ovf_next;
    logic               r_out_valid;
    logic [ACC_W-1:0]   r_out_total;
    logic [CNT_W-1:0]   r_out_count;
    logic [IN_W-1:0]    r_out_max;
    logic               r_out_overflow;
    logic               w_accept, w_close;
    logic [ACC_W:0]     w_sum;

    assign in_ready     = (r_state == ACCUM);
    assign out_valid    = r_out_valid;
    assign out_total    = r_out_total;
    assign out_count    = r_out_count;
    assign out_max      = r_out_max;
    assign out_overflow = r_out_overflow;

    always_comb begin
        w_accept   = in_valid && (r_state == ACCUM);
        w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(in_sum);
        w_acc_next = r_acc;
        w_cnt_next = r_cnt;
        w_max_next = r_max;
        w_ovf_next = r_ovf;
        if (w_accept) begin
            w_acc_next = w_sum[ACC_W-1:0];
            w_ovf_next = r_ovf | w_sum[ACC_W];
            w_max_next = (in_sum > r_max) ? in_sum : r_max;
            w_cnt_next = r_cnt + CNT_W'(1);
        end
        // A flush on an empty block produces nothing.
        w_close = (r_state == ACCUM) &&
                  ((w_accept && (r_cnt == CNT_W'(BLOCK_LEN - 1))) ||
                   (flush && ((r_cnt != '0) || w_accept)));
        w_state_next = r_state;
        case (r_state)
            ACCUM: if (w_close)   w_state_next = HOLD;
            HOLD:  if (out_ready) w_state_next = ACCUM;
            default:              w_state_next = ACCUM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state        <= ACCUM;
            r_acc          <= '0;
            r_cnt          <= '0;
            r_max          <= '0;
            r_ovf          <= 1'b0;
            r_out_valid    <= 1'b0;
            r_out_total    <= '0;
            r_out_count    <= '0;
            r_out_max      <= '0;
            r_out_overflow <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_close) begin
                r_out_total    <= w_acc_next;
                r_out_count    <= w_cnt_next;
                r_out_max      <= w_max_next;
                r_out_overflow <= w_ovf_next;
                r_out_valid    <= 1'b1;
                r_acc          <= '0;
                r_cnt          <= '0;
                r_max          <= '0;
                r_ovf          <= 1'b0;
            end else begin
                r_acc <= w_acc_next;
                r_cnt <= w_cnt_next;
                r_max <= w_max_next;
                r_ovf <= w_ovf_next;
            end
            // Output data keep their last value after the handshake.
            if ((r_state == HOLD) && out_ready)
                r_out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_sum_block_accumulator.sv
// Self-checking bench: BLOCK_LEN=4 instance checked against a sample-queue model,
// plus a BLOCK_LEN=16 instance for the accumulator overflow case.
module tb_sum_block_accumulator;

    localparam int IN_W = 5;
    localparam int ACC_W = 8;
    localparam int BL = 4;
    localparam int CW = $clog2(BL + 1);
    localparam int BL2 = 16;
    localparam int CW2 = $clog2(BL2 + 1);

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic a_rst = 1'b1, a_in_valid = 1'b0, a_flush = 1'b0, a_out_ready = 1'b0;
    logic [IN_W-1:0] a_in_sum = '0;
    logic a_in_ready, a_out_valid, a_out_overflow;
    logic [ACC_W-1:0] a_out_total;
    logic [CW-1:0] a_out_count;
    logic [IN_W-1:0] a_out_max;

    logic b_rst = 1'b1, b_in_valid = 1'b0, b_flush = 1'b0, b_out_ready = 1'b0;
    logic [IN_W-1:0] b_in_sum = '0;
    logic b_in_ready, b_out_valid, b_out_overflow;
    logic [ACC_W-1:0] b_out_total;
    logic [CW2-1:0] b_out_count;
    logic [IN_W-1:0] b_out_max;

    sum_block_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .BLOCK_LEN(BL)) dut_a (
        .clk(clk), .rst(a_rst), .in_valid(a_in_valid), .in_sum(a_in_sum),
        .in_ready(a_in_ready), .flush(a_flush), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .out_total(a_out_total), .out_count(a_out_count),
        .out_max(a_out_max), .out_overflow(a_out_overflow));

    sum_block_accumulator #(.IN_W(IN_W), .ACC_W(ACC_W), .BLOCK_LEN(BL2)) dut_b (
        .clk(clk), .rst(b_rst), .in_valid(b_in_valid), .in_sum(b_in_sum),
        .in_ready(b_in_ready), .flush(b_flush), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .out_total(b_out_total), .out_count(b_out_count),
        .out_max(b_out_max), .out_overflow(b_out_overflow));

    wire [17:0] a_obs = {a_out_valid, a_out_total, a_out_count, a_out_max, a_out_overflow};
    wire [19:0] b_obs = {b_out_valid, b_out_total, b_out_count, b_out_max, b_out_overflow};

    int checks = 0;
    int failures = 0;

    // Reference model: list of samples in the open block, plus the last reported result.
    bit m_pend = 0;
    int m_q[$];
    int e_total = 0, e_count = 0, e_max = 0;
    bit e_ovf = 0;

    function automatic logic [17:0] a_exp();
        return {m_pend, 8'(e_total), 3'(e_count), 5'(e_max), e_ovf};
    endfunction

    task automatic step(input bit r, input bit v, input int s, input bit f, input bit o);
        int sum, mx;
        a_rst = r; a_in_valid = v; a_in_sum = IN_W'(s); a_flush = f; a_out_ready = o;
        @(posedge clk);
        if (r) begin
            m_pend = 0; m_q.delete();
            e_total = 0; e_count = 0; e_max = 0; e_ovf = 0;
        end else if (m_pend) begin
            if (o) m_pend = 0;
        end else begin
            if (v) m_q.push_back(s);
            if (m_q.size() == BL || (f && m_q.size() > 0)) begin
                sum = 0; mx = 0;
                foreach (m_q[i]) begin
                    sum += m_q[i];
                    if (m_q[i] > mx) mx = m_q[i];
                end
                e_total = sum % 256; e_count = m_q.size(); e_max = mx; e_ovf = (sum > 255);
                m_pend = 1;
                m_q.delete();
            end
        end
        #1;
    endtask

    task automatic test_reset();
        step(1, 0, 0, 0, 0);
        step(1, 1, 17, 1, 0);
        checks++;
        if (a_obs !== 18'h0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset: obs=%h rdy=%b want obs=0 rdy=1", a_obs, a_in_ready);
        end
        step(0, 0, 0, 0, 0);
    endtask

    task automatic test_basic();
        int smp[4] = '{3, 7, 30, 31};
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_obs !== a_exp() || a_in_ready !== 1'b1) begin
                failures++;
                $display("FAIL basic_pre%0d: obs=%h rdy=%b want %h rdy=1", i, a_obs, a_in_ready, a_exp());
            end
            step(0, 1, smp[i], 0, 0);
        end
        checks++;
        if (a_obs !== {1'b1, 8'd71, 3'd4, 5'd31, 1'b0} || a_in_ready !== 1'b0) begin
            failures++;
            $display("FAIL basic_result: obs=%h rdy=%b want %h rdy=0", a_obs, a_in_ready,
                     {1'b1, 8'd71, 3'd4, 5'd31, 1'b0});
        end
        step(0, 0, 0, 0, 1);
        checks++;
        if (a_obs !== a_exp() || a_in_ready !== 1'b1 || a_out_valid !== 1'b0) begin
            failures++;
            $display("FAIL basic_handshake: obs=%h rdy=%b want %h rdy=1", a_obs, a_in_ready, a_exp());
        end
    endtask

    task automatic test_backpressure();
        logic [17:0] held;
        for (int i = 0; i < 4; i++) step(0, 1, $urandom_range(0, 31), 0, 0);
        held = a_exp();
        for (int i = 0; i < 5; i++) begin
            step(0, 1, 9, 0, 0);
            checks++;
            if (a_obs !== held || a_in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold%0d: obs=%h rdy=%b want %h rdy=0", i, a_obs, a_in_ready, held);
            end
        end
        step(0, 1, 9, 0, 1);
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL bp_release: valid=%b rdy=%b want valid=0 rdy=1", a_out_valid, a_in_ready);
        end
        step(0, 1, 9, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        step(0, 1, 1, 0, 0);
        checks++;
        if (a_obs !== a_exp() || a_out_total !== 8'd12 || a_out_max !== 5'd9) begin
            failures++;
            $display("FAIL bp_next_block: obs=%h want %h (total 12 max 9)", a_obs, a_exp());
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_flush();
        step(0, 1, 5, 0, 0);
        step(0, 1, 6, 0, 0);
        step(0, 0, 0, 1, 0);
        checks++;
        if (a_obs !== {1'b1, 8'd11, 3'd2, 5'd6, 1'b0}) begin
            failures++;
            $display("FAIL flush_idle: obs=%h want %h", a_obs, {1'b1, 8'd11, 3'd2, 5'd6, 1'b0});
        end
        step(0, 0, 0, 1, 1);
        step(0, 1, 5, 0, 0);
        step(0, 1, 4, 1, 0);
        checks++;
        if (a_obs !== {1'b1, 8'd9, 3'd2, 5'd5, 1'b0}) begin
            failures++;
            $display("FAIL flush_accept: obs=%h want %h", a_obs, {1'b1, 8'd9, 3'd2, 5'd5, 1'b0});
        end
        step(0, 0, 0, 0, 1);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        checks++;
        if (a_out_valid !== 1'b0 || a_obs !== a_exp()) begin
            failures++;
            $display("FAIL flush_empty: obs=%h want %h", a_obs, a_exp());
        end
    endtask

    task automatic test_reset_mid();
        step(0, 1, 20, 0, 0);
        step(0, 1, 20, 0, 0);
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 4; i++) step(0, 1, 1, 0, 0);
        checks++;
        if (a_obs !== {1'b1, 8'd4, 3'd4, 5'd1, 1'b0}) begin
            failures++;
            $display("FAIL reset_mid: obs=%h want %h", a_obs, {1'b1, 8'd4, 3'd4, 5'd1, 1'b0});
        end
        step(1, 0, 0, 0, 0);
        checks++;
        if (a_obs !== 18'h0 || a_in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_pending: obs=%h rdy=%b want 0 rdy=1", a_obs, a_in_ready);
        end
    endtask

    task automatic test_gapped();
        for (int i = 0; i < 7; i++) begin
            step(0, (i % 2) == 0, 2, 0, 0);
            checks++;
            if (a_obs !== a_exp()) begin
                failures++;
                $display("FAIL gapped%0d: obs=%h want %h", i, a_obs, a_exp());
            end
        end
        checks++;
        if (a_out_valid !== 1'b1 || a_out_total !== 8'd8 || a_out_count !== 3'd4) begin
            failures++;
            $display("FAIL gapped_total: total=%0d count=%0d want 8/4", a_out_total, a_out_count);
        end
        step(0, 0, 0, 0, 1);
    endtask

    task automatic test_random();
        bit v, f, o;
        int bad = 0;
        for (int i = 0; i < 400; i++) begin
            v = ($urandom_range(0, 3) != 0);
            f = ($urandom_range(0, 9) == 0);
            o = ($urandom_range(0, 1) == 1);
            checks++;
            if (a_in_ready !== !m_pend) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL rand_ready%0d: rdy=%b want %b", i, a_in_ready, !m_pend);
            end
            step(0, v, $urandom_range(0, 31), f, o);
            checks++;
            if (a_obs !== a_exp()) begin
                failures++; bad++;
                if (bad < 10) $display("FAIL rand_out%0d: obs=%h want %h", i, a_obs, a_exp());
            end
        end
    endtask

    task automatic test_overflow();
        int sum;
        logic [19:0] want;
        b_rst = 1'b1;
        @(posedge clk); #1;
        b_rst = 1'b0;
        sum = 0;
        for (int i = 0; i < BL2; i++) begin
            b_in_valid = 1'b1; b_in_sum = 5'd31; sum += 31;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        want = {1'b1, 8'(sum % 256), 5'(BL2), 5'd31, 1'b1};
        checks++;
        if (b_obs !== want) begin
            failures++;
            $display("FAIL overflow_block: obs=%h want %h", b_obs, want);
        end
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        for (int i = 0; i < BL2; i++) begin
            b_in_valid = 1'b1; b_in_sum = 5'd1;
            @(posedge clk); #1;
        end
        b_in_valid = 1'b0;
        want = {1'b1, 8'd16, 5'(BL2), 5'd1, 1'b0};
        checks++;
        if (b_obs !== want) begin
            failures++;
            $display("FAIL overflow_clear: obs=%h want %h", b_obs, want);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_flush();
        test_reset_mid();
        test_gapped();
        test_random();
        test_overflow();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
